// File: rtl/vec_cache_sram_2inst_issue.sv
// Initiator-side issue scheduler for the two-instance SRAM group: arbitrates two requesters,
// packs granted reads/writes onto group ports a/b and returns tagged read data after RD_LAT.
package vec_cache_sram_pkg;
   typedef struct packed {
      logic       channel_id;
      logic [2:0] bank_id;
   } sram_ram_id_t;

   typedef struct packed {
      sram_ram_id_t dest_ram_id;
      logic [11:0]  addr;
   } sram_inst_cmd_t;
endpackage

module vec_cache_sram_2inst_issue
   import vec_cache_sram_pkg::*;
#(
   parameter int TAG_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_vld_0,
   input  logic                 req_vld_1,
   output logic                 req_rdy_0,
   output logic                 req_rdy_1,
   input  logic                 req_wr_0,
   input  logic                 req_wr_1,
   input  sram_inst_cmd_t       req_cmd_0,
   input  sram_inst_cmd_t       req_cmd_1,
   input  logic [31:0]          req_wdata_0,
   input  logic [31:0]          req_wdata_1,
   input  logic [TAG_W-1:0]     req_tag_0,
   input  logic [TAG_W-1:0]     req_tag_1,
   output logic                 read_vld_a,
   output logic                 read_vld_b,
   output logic                 write_vld_a,
   output logic                 write_vld_b,
   output sram_inst_cmd_t       read_cmd_a,
   output sram_inst_cmd_t       read_cmd_b,
   output sram_inst_cmd_t       write_cmd_a,
   output sram_inst_cmd_t       write_cmd_b,
   output logic [31:0]          wr_data_a,
   output logic [31:0]          wr_data_b,
   input  logic [31:0]          rd_data_a,
   input  logic [31:0]          rd_data_b,
   output logic                 rsp_vld_0,
   output logic                 rsp_vld_1,
   output logic [31:0]          rsp_data_0,
   output logic [31:0]          rsp_data_1,
   output logic [TAG_W-1:0]     rsp_tag_0,
   output logic [TAG_W-1:0]     rsp_tag_1,
   output logic [15:0]          conflict_cnt
);

   typedef struct packed {
      logic             vld;
      logic             id;
      logic [TAG_W-1:0] tag;
   } trk_t;

   logic           conflict;
   logic           rr;
   logic           grant_0, grant_1;
   logic           rd_0, rd_1, wr_0, wr_1;

   logic           nxt_read_vld_a, nxt_read_vld_b, nxt_write_vld_a, nxt_write_vld_b;
   sram_inst_cmd_t nxt_read_cmd_a, nxt_read_cmd_b, nxt_write_cmd_a, nxt_write_cmd_b;
   logic [31:0]    nxt_wr_data_a, nxt_wr_data_b;
   trk_t           nxt_trk_a, nxt_trk_b;

   trk_t           trk_a [0:RD_LAT];
   trk_t           trk_b [0:RD_LAT];
   logic           hit_a0, hit_a1, hit_b0, hit_b1;

   // rr names the winner of the next conflict; both instances are single-port.
   assign conflict  = req_vld_0 & req_vld_1 &
                      (req_cmd_0.dest_ram_id.channel_id == req_cmd_1.dest_ram_id.channel_id);
   assign req_rdy_0 = ~rst & ~(conflict & rr);
   assign req_rdy_1 = ~rst & ~(conflict & ~rr);
   assign grant_0   = req_vld_0 & req_rdy_0;
   assign grant_1   = req_vld_1 & req_rdy_1;
   assign rd_0      = grant_0 & ~req_wr_0;
   assign rd_1      = grant_1 & ~req_wr_1;
   assign wr_0      = grant_0 & req_wr_0;
   assign wr_1      = grant_1 & req_wr_1;

   // Port a is always filled first so the crossbar can steer on its channel_id alone.
   always_comb begin
      nxt_read_vld_a  = rd_0 | rd_1;
      nxt_read_vld_b  = rd_0 & rd_1;
      nxt_read_cmd_a  = '0;
      nxt_read_cmd_b  = '0;
      nxt_trk_a       = '0;
      nxt_trk_b       = '0;
      if (rd_0) begin
         nxt_read_cmd_a = req_cmd_0;
         nxt_trk_a      = '{vld: 1'b1, id: 1'b0, tag: req_tag_0};
      end else if (rd_1) begin
         nxt_read_cmd_a = req_cmd_1;
         nxt_trk_a      = '{vld: 1'b1, id: 1'b1, tag: req_tag_1};
      end
      if (rd_0 && rd_1) begin
         nxt_read_cmd_b = req_cmd_1;
         nxt_trk_b      = '{vld: 1'b1, id: 1'b1, tag: req_tag_1};
      end

      nxt_write_vld_a = wr_0 | wr_1;
      nxt_write_vld_b = wr_0 & wr_1;
      nxt_write_cmd_a = '0;
      nxt_write_cmd_b = '0;
      nxt_wr_data_a   = '0;
      nxt_wr_data_b   = '0;
      if (wr_0) begin
         nxt_write_cmd_a = req_cmd_0;
         nxt_wr_data_a   = req_wdata_0;
      end else if (wr_1) begin
         nxt_write_cmd_a = req_cmd_1;
         nxt_wr_data_a   = req_wdata_1;
      end
      if (wr_0 && wr_1) begin
         nxt_write_cmd_b = req_cmd_1;
         nxt_wr_data_b   = req_wdata_1;
      end
   end

   // The last tracking stage lines up with rd_data_a/b of the matching command.
   assign hit_a0 = trk_a[RD_LAT].vld & ~trk_a[RD_LAT].id;
   assign hit_a1 = trk_a[RD_LAT].vld &  trk_a[RD_LAT].id;
   assign hit_b0 = trk_b[RD_LAT].vld & ~trk_b[RD_LAT].id;
   assign hit_b1 = trk_b[RD_LAT].vld &  trk_b[RD_LAT].id;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr           <= 1'b0;
         conflict_cnt <= '0;
         read_vld_a   <= 1'b0;
         read_vld_b   <= 1'b0;
         write_vld_a  <= 1'b0;
         write_vld_b  <= 1'b0;
         read_cmd_a   <= '0;
         read_cmd_b   <= '0;
         write_cmd_a  <= '0;
         write_cmd_b  <= '0;
         wr_data_a    <= '0;
         wr_data_b    <= '0;
         rsp_vld_0    <= 1'b0;
         rsp_vld_1    <= 1'b0;
         rsp_data_0   <= '0;
         rsp_data_1   <= '0;
         rsp_tag_0    <= '0;
         rsp_tag_1    <= '0;
         for (int i = 0; i <= RD_LAT; i++) begin
            trk_a[i] <= '0;
            trk_b[i] <= '0;
         end
      end else begin
         if (conflict) begin
            rr <= ~rr;
            if (conflict_cnt != 16'hFFFF)
               conflict_cnt <= conflict_cnt + 16'd1;
         end
         read_vld_a  <= nxt_read_vld_a;
         read_vld_b  <= nxt_read_vld_b;
         write_vld_a <= nxt_write_vld_a;
         write_vld_b <= nxt_write_vld_b;
         read_cmd_a  <= nxt_read_cmd_a;
         read_cmd_b  <= nxt_read_cmd_b;
         write_cmd_a <= nxt_write_cmd_a;
         write_cmd_b <= nxt_write_cmd_b;
         wr_data_a   <= nxt_wr_data_a;
         wr_data_b   <= nxt_wr_data_b;

         trk_a[0] <= nxt_trk_a;
         trk_b[0] <= nxt_trk_b;
         for (int i = 1; i <= RD_LAT; i++) begin
            trk_a[i] <= trk_a[i-1];
            trk_b[i] <= trk_b[i-1];
         end

         rsp_vld_0  <= hit_a0 | hit_b0;
         rsp_vld_1  <= hit_a1 | hit_b1;
         rsp_data_0 <= hit_a0 ? rd_data_a : (hit_b0 ? rd_data_b : '0);
         rsp_data_1 <= hit_a1 ? rd_data_a : (hit_b1 ? rd_data_b : '0);
         rsp_tag_0  <= hit_a0 ? trk_a[RD_LAT].tag : (hit_b0 ? trk_b[RD_LAT].tag : '0);
         rsp_tag_1  <= hit_a1 ? trk_a[RD_LAT].tag : (hit_b1 ? trk_b[RD_LAT].tag : '0);
      end
   end

endmodule

// File: tb/tb_vec_cache_sram_2inst_issue.sv
// Random and directed stimulus for the two-requester SRAM issue scheduler, checked against a
// cycle-indexed behavioural model of grants, port packing and read-response timing.
module tb_vec_cache_sram_2inst_issue;
   import vec_cache_sram_pkg::*;

   localparam int TAG_W  = 8;
   localparam int RD_LAT = 1;
   localparam int NIT    = 4096;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_vld_0, req_vld_1, req_rdy_0, req_rdy_1, req_wr_0, req_wr_1;
   sram_inst_cmd_t req_cmd_0, req_cmd_1;
   logic [31:0]    req_wdata_0, req_wdata_1;
   logic [7:0]     req_tag_0, req_tag_1;
   logic           read_vld_a, read_vld_b, write_vld_a, write_vld_b;
   sram_inst_cmd_t read_cmd_a, read_cmd_b, write_cmd_a, write_cmd_b;
   logic [31:0]    wr_data_a, wr_data_b, rd_data_a, rd_data_b;
   logic           rsp_vld_0, rsp_vld_1;
   logic [31:0]    rsp_data_0, rsp_data_1;
   logic [7:0]     rsp_tag_0, rsp_tag_1;
   logic [15:0]    conflict_cnt;

   always #5 clk = ~clk;

   vec_cache_sram_2inst_issue #(.TAG_W(TAG_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_vld_0(req_vld_0), .req_vld_1(req_vld_1),
      .req_rdy_0(req_rdy_0), .req_rdy_1(req_rdy_1),
      .req_wr_0(req_wr_0), .req_wr_1(req_wr_1),
      .req_cmd_0(req_cmd_0), .req_cmd_1(req_cmd_1),
      .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
      .req_tag_0(req_tag_0), .req_tag_1(req_tag_1),
      .read_vld_a(read_vld_a), .read_vld_b(read_vld_b),
      .write_vld_a(write_vld_a), .write_vld_b(write_vld_b),
      .read_cmd_a(read_cmd_a), .read_cmd_b(read_cmd_b),
      .write_cmd_a(write_cmd_a), .write_cmd_b(write_cmd_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rsp_vld_0(rsp_vld_0), .rsp_vld_1(rsp_vld_1),
      .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
      .rsp_tag_0(rsp_tag_0), .rsp_tag_1(rsp_tag_1),
      .conflict_cnt(conflict_cnt)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: round-robin winner, conflict count, and per-iteration port-a/b read issue log.
   int             it       = 0;
   int             last_rst = -1;
   int             m_rr     = 0;
   int             m_cnt    = 0;
   logic           pa_v [NIT];
   logic           pb_v [NIT];
   int             pa_id [NIT];
   int             pb_id [NIT];
   logic [7:0]     pa_tag [NIT];
   logic [7:0]     pb_tag [NIT];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s it=%0d: got %0h expected %0h", tag, it, obs, exp);
      end
   endtask

   // One clock: check rdy, predict next outputs, advance the clock, check registered outputs.
   task automatic step();
      logic           v [2];
      logic           w [2];
      sram_inst_cmd_t c [2];
      logic [31:0]    d [2];
      logic [7:0]     t [2];
      logic           g [2];
      logic           conf;
      int             rds [$];
      int             wrs [$];
      int             k0;
      logic           e_rva, e_rvb, e_wva, e_wvb;
      sram_inst_cmd_t e_rca, e_rcb, e_wca, e_wcb;
      logic [31:0]    e_wda, e_wdb;
      logic           e_rsp_v [2];
      logic [31:0]    e_rsp_d [2];
      logic [7:0]     e_rsp_t [2];

      v[0] = req_vld_0; v[1] = req_vld_1;
      w[0] = req_wr_0;  w[1] = req_wr_1;
      c[0] = req_cmd_0; c[1] = req_cmd_1;
      d[0] = req_wdata_0; d[1] = req_wdata_1;
      t[0] = req_tag_0; t[1] = req_tag_1;
      if (rst) last_rst = it;

      conf = !rst && v[0] && v[1] &&
             (c[0].dest_ram_id.channel_id == c[1].dest_ram_id.channel_id);
      g[0] = !rst && v[0] && !(conf && m_rr == 1);
      g[1] = !rst && v[1] && !(conf && m_rr == 0);

      #1;
      check_val("req_rdy_0", req_rdy_0, !rst && !(conf && m_rr == 1));
      check_val("req_rdy_1", req_rdy_1, !rst && !(conf && m_rr == 0));

      for (int i = 0; i < 2; i++)
         if (g[i]) begin
            if (w[i]) wrs.push_back(i);
            else      rds.push_back(i);
         end

      e_rva = rds.size() > 0; e_rvb = rds.size() > 1;
      e_wva = wrs.size() > 0; e_wvb = wrs.size() > 1;
      e_rca = '0; e_rcb = '0; e_wca = '0; e_wcb = '0; e_wda = '0; e_wdb = '0;
      pa_v[it] = e_rva; pb_v[it] = e_rvb;
      pa_id[it] = 0; pb_id[it] = 0; pa_tag[it] = '0; pb_tag[it] = '0;
      if (e_rva) begin
         e_rca = c[rds[0]]; pa_id[it] = rds[0]; pa_tag[it] = t[rds[0]];
      end
      if (e_rvb) begin
         e_rcb = c[rds[1]]; pb_id[it] = rds[1]; pb_tag[it] = t[rds[1]];
      end
      if (e_wva) begin
         e_wca = c[wrs[0]]; e_wda = d[wrs[0]];
      end
      if (e_wvb) begin
         e_wcb = c[wrs[1]]; e_wdb = d[wrs[1]];
      end

      // rd_data driven now belongs to reads accepted 1+RD_LAT iterations ago, unless reset since.
      e_rsp_v[0] = 1'b0; e_rsp_v[1] = 1'b0;
      e_rsp_d[0] = '0; e_rsp_d[1] = '0; e_rsp_t[0] = '0; e_rsp_t[1] = '0;
      k0 = it - 1 - RD_LAT;
      if (k0 >= 0 && last_rst <= k0) begin
         if (pa_v[k0]) begin
            e_rsp_v[pa_id[k0]] = 1'b1; e_rsp_d[pa_id[k0]] = rd_data_a; e_rsp_t[pa_id[k0]] = pa_tag[k0];
         end
         if (pb_v[k0]) begin
            e_rsp_v[pb_id[k0]] = 1'b1; e_rsp_d[pb_id[k0]] = rd_data_b; e_rsp_t[pb_id[k0]] = pb_tag[k0];
         end
      end

      @(posedge clk);
      if (rst) begin
         m_rr = 0; m_cnt = 0;
      end else if (conf) begin
         m_rr = (m_rr == 0) ? 1 : 0;
         if (m_cnt < 65535) m_cnt++;
      end
      @(negedge clk);

      check_val("read_vld_a", read_vld_a, e_rva);
      if (e_rva) check_val("read_cmd_a", read_cmd_a, e_rca);
      check_val("read_vld_b", read_vld_b, e_rvb);
      check_val("read_cmd_b", read_cmd_b, e_rcb);
      check_val("write_vld_a", write_vld_a, e_wva);
      if (e_wva) begin
         check_val("write_cmd_a", write_cmd_a, e_wca);
         check_val("wr_data_a", wr_data_a, e_wda);
      end
      check_val("write_vld_b", write_vld_b, e_wvb);
      check_val("write_cmd_b", write_cmd_b, e_wcb);
      check_val("wr_data_b", wr_data_b, e_wdb);
      check_val("rsp_vld_0", rsp_vld_0, e_rsp_v[0]);
      check_val("rsp_vld_1", rsp_vld_1, e_rsp_v[1]);
      if (e_rsp_v[0]) begin
         check_val("rsp_data_0", rsp_data_0, e_rsp_d[0]);
         check_val("rsp_tag_0", rsp_tag_0, e_rsp_t[0]);
      end
      if (e_rsp_v[1]) begin
         check_val("rsp_data_1", rsp_data_1, e_rsp_d[1]);
         check_val("rsp_tag_1", rsp_tag_1, e_rsp_t[1]);
      end
      check_val("conflict_cnt", conflict_cnt, m_cnt);
      it++;
   endtask

   task automatic set_idle();
      rst = 1'b0;
      req_vld_0 = 1'b0; req_vld_1 = 1'b0; req_wr_0 = 1'b0; req_wr_1 = 1'b0;
      req_cmd_0 = '0; req_cmd_1 = '0; req_wdata_0 = '0; req_wdata_1 = '0;
      req_tag_0 = '0; req_tag_1 = '0;
      rd_data_a = $urandom; rd_data_b = $urandom;
   endtask

   task automatic rand_stim();
      rst         = ($urandom_range(0, 99) < 2);
      req_vld_0   = ($urandom_range(0, 99) < 70);
      req_vld_1   = ($urandom_range(0, 99) < 70);
      req_wr_0    = ($urandom_range(0, 99) < 40);
      req_wr_1    = ($urandom_range(0, 99) < 40);
      req_cmd_0   = sram_inst_cmd_t'($urandom);
      req_cmd_1   = sram_inst_cmd_t'($urandom);
      req_wdata_0 = $urandom;
      req_wdata_1 = $urandom;
      req_tag_0   = 8'($urandom);
      req_tag_1   = 8'($urandom);
      rd_data_a   = $urandom;
      rd_data_b   = $urandom;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      step();
      step();
      check_val("reset_cnt", conflict_cnt, 16'd0);
      check_val("reset_rsp_vld_0", rsp_vld_0, 1'b0);

      // Single read from requester 0, then DEADBEEF returned on the matching cycle.
      set_idle();
      req_vld_0 = 1'b1; req_cmd_0 = '0; req_cmd_0.addr = 12'h123; req_tag_0 = 8'h5A;
      step();
      set_idle(); rd_data_a = 32'hDEADBEEF;
      step();
      step();
      check_val("single_rsp_data", rsp_data_0, 32'hDEADBEEF);
      check_val("single_rsp_tag", rsp_tag_0, 8'h5A);
      set_idle();
      step();

      // Persistent same-channel conflict for four cycles after a fresh reset.
      set_idle(); rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         set_idle();
         req_vld_0 = 1'b1; req_vld_1 = 1'b1;
         req_cmd_0.dest_ram_id.channel_id = 1'b1; req_cmd_1.dest_ram_id.channel_id = 1'b1;
         req_tag_0 = 8'(i); req_tag_1 = 8'(i + 16);
         step();
      end
      check_val("conflict_cnt_4", conflict_cnt, 16'd4);

      // Write from 0 vs read from 1 on ch 0, with rr back at 0 after reset.
      set_idle(); rst = 1'b1;
      step();
      set_idle();
      req_vld_0 = 1'b1; req_wr_0 = 1'b1; req_wdata_0 = 32'h0BADF00D;
      req_vld_1 = 1'b1; req_tag_1 = 8'h77;
      step();
      set_idle();
      req_vld_1 = 1'b1; req_tag_1 = 8'h77;
      step();
      set_idle();
      step();
      step();

      // Reset one cycle after a read is accepted drops its response.
      set_idle();
      req_vld_1 = 1'b1; req_tag_1 = 8'h33;
      step();
      set_idle(); rst = 1'b1;
      step();
      set_idle();
      step();
      step();

      for (int n = 0; n < 3000; n++) begin
         rand_stim();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_cache_sram_2inst_issue.md
# vec_cache_sram_2inst_issue

Issue scheduler on the initiator side of the two-instance SRAM group: accepts read/write requests from two requesters, resolves hash-group conflicts (both targeting the same `channel_id`), and drives the group's crossbar-steered command ports. It tracks outstanding reads through the fixed SRAM read latency and returns tagged read data to the originating requester. Sits between the vector-cache bank pipeline and the 2-instance SRAM group.

## Interface
- `TAG_W`, 8: width of the request/response tag.
- `RD_LAT`, 1: cycles from group read command valid to `rd_data_*` valid; must be ≥1.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; one clock `clk`, reset `rst` is synchronous and active-high.
- `req_vld_0`, `req_vld_1`  in  1  request valid from requester 0/1.
- `req_rdy_0`, `req_rdy_1`  out  1  request accepted when vld&rdy.
- `req_wr_0`, `req_wr_1`  in  1  1 = write, 0 = read.
- `req_cmd_0`, `req_cmd_1`  in  `sram_inst_cmd_t`  command; `dest_ram_id.channel_id` selects SRAM instance.
- `req_wdata_0`, `req_wdata_1`  in  32  write data.
- `req_tag_0`, `req_tag_1`  in  TAG_W  returned with read response.
- `read_vld_a/b`, `write_vld_a/b`  out  1  group command valids.
- `read_cmd_a/b`, `write_cmd_a/b`  out  `sram_inst_cmd_t`  group commands.
- `wr_data_a/b`  out  32  group write data.
- `rd_data_a/b`  in  32  group read data, valid `RD_LAT` cycles after the matching read command.
- `rsp_vld_0`, `rsp_vld_1`  out  1  read response valid (no backpressure).
- `rsp_data_0`, `rsp_data_1`  out  32  read data.
- `rsp_tag_0`, `rsp_tag_1`  out  TAG_W  tag of the original read.
- `conflict_cnt`  out  16  saturating count of conflict cycles.

## Operation
- Conflict: both `req_vld` high and `channel_id` equal, regardless of op. SRAM instances are single-port: one access (read or write) per instance per cycle.
- No conflict: both requests granted (`req_rdy_0 = req_rdy_1 = 1`).
- Conflict: round-robin pointer `rr` (reset 0) selects the winner. `rr=0` means requester 0 wins. On each conflict cycle, `rr` is set to the loser's index, so the loser wins the next conflict. A loser that stays valid is therefore granted within 1 cycle.
- `req_rdy_i` is combinational from the current inputs and `rr`. It is 0 only for the conflict loser and during `rst`.
- Port packing, per op type independently:
  - Two granted requests of the same type: requester 0 → port a, requester 1 → port b.
  - One granted request: port a; port b valid 0 with cmd/data driven 0.
  - Port a always carries a valid request whenever any request of that type is issued. The crossbar steers by port a's `channel_id`, so port b is always routed to the other instance.
- Issue stage registers all group outputs (valid, cmd, wdata).
- Read tracking: a shift pipeline of depth `RD_LAT+1` carries, for each port, {valid, requester id, tag}. When `rd_data_a/b` is valid, its data is routed to the owning requester's response register.
- Two reads to the same requester in one cycle are impossible: each requester issues at most one request per cycle.
- `conflict_cnt` increments on every conflict cycle and saturates at 16'hFFFF.

## Timing
- Request accepted at cycle T → group command valid at T+1 → `rd_data` at T+1+`RD_LAT` → `rsp_vld` at T+2+`RD_LAT`. With the default `RD_LAT`=1, the response arrives at T+3.
- Writes produce no response.
- Throughput: 2 requests/cycle when there is no conflict; 1/cycle when there is a conflict.
- Reset values: every `*_vld` output 0; all cmd/data/tag outputs 0; `rr` 0; tracking pipeline cleared; `conflict_cnt` 0; `req_rdy_*` 0 while `rst` is high.
- Reset mid-operation: all in-flight reads are dropped and no response is emitted for them. The first accept is possible in the cycle after `rst` deasserts.
- Back-to-back conflicts alternate the winner every cycle.

## Test plan
- Single read, requester 0, channel_id 0, tag 8'h5A: `read_vld_a` at T+1 with `read_vld_b`=0. Drive `rd_data_a`=32'hDEADBEEF at T+2 → `rsp_vld_0`, data 32'hDEADBEEF, tag 8'h5A at T+3; `rsp_vld_1` stays 0.
- Reads from req0 (ch 1, tag 1) and req1 (ch 0, tag 2) in the same cycle: both rdy=1; port a carries req0, port b carries req1. Return `rd_data_a`=A and `rd_data_b`=B → rsp_0 gets (A, 1) and rsp_1 gets (B, 2) in the same cycle.
- Persistent conflict, both requesters ch 1, held valid for 4 cycles: the granted requester alternates 0,1,0,1; `conflict_cnt` reaches 4.
- Write from req0 and read from req1 on ch 0 (conflict, `rr`=0): req0's write is issued on `write_*_a`; req1 has rdy=0 that cycle and its read is issued on `read_*_a` the next cycle.
- Only req1 reading, ch 0: request is issued on port a (`read_cmd_a` channel_id 0); response returned on rsp_1.
- `rst` asserted one cycle after a read is accepted: no `rsp_vld` for that read; all outputs read 0 during reset.
